// File: rtl/sdc_arb_pkg.sv
// Shared definitions for the SDRAM-controller host-port arbiter:
// FSM encoding and the burst-code decode.
package sdc_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_WDATA = 2'd2,
    ST_RDATA = 2'd3
  } state_t;

  localparam int BEAT_W = 4;

  // Burst code to beat count: 0 -> 1, 1 -> 2, 2 -> 4, 3 -> 8.
  function automatic logic [BEAT_W-1:0] len_to_beats(input logic [1:0] len);
    return BEAT_W'(1) << len;
  endfunction

endpackage

// File: rtl/sdc_host_arb_rr_pick.sv
// Combinational round-robin priority encoder: first requester at or after
// ptr, wrapping modulo NREQ.
module rr_pick #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0] req,
  input  logic [2:0]      ptr,
  output logic [2:0]      grant,
  output logic            any
);

  always_comb begin
    int idx;
    idx   = 0;
    grant = '0;
    any   = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr) + k) % NREQ;
      if (!any && req[idx]) begin
        grant = 3'(idx);
        any   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sdc_host_arb.sv
// Round-robin arbiter sharing the single SDRAM-controller host port among
// NREQ masters; a grant is held from request through the last data beat.
module sdc_host_arb
  import sdc_arb_pkg::*;
#(
  parameter int NREQ   = 4,
  parameter int ADDR_W = 22,
  parameter int DATA_W = 32
) (
  input  logic                     mclk,
  input  logic                     s_reset,
  input  logic [NREQ-1:0]          m_req,
  input  logic [NREQ*ADDR_W-1:0]   m_adr,
  input  logic [NREQ*2-1:0]        m_len,
  input  logic [NREQ-1:0]          m_wr_n,
  input  logic [NREQ*DATA_W-1:0]   m_wr_data,
  input  logic [NREQ*4-1:0]        m_wr_en_n,
  output logic [NREQ-1:0]          m_ack,
  output logic [NREQ-1:0]          m_wr_next,
  output logic [NREQ-1:0]          m_rd_valid,
  input  logic                     sdr_init_done,
  output logic                     sdr_req,
  output logic [ADDR_W-1:0]        sdr_req_adr,
  output logic [1:0]               sdr_req_len,
  output logic                     sdr_req_wr_n,
  output logic [DATA_W-1:0]        sdr_wr_data,
  output logic [3:0]               sdr_wr_en_n,
  input  logic                     sdr_req_ack,
  input  logic                     sdr_wr_next,
  input  logic                     sdr_rd_valid,
  output logic                     busy,
  output logic [2:0]               owner
);

  state_t              state, state_nxt;
  logic [2:0]          owner_q, owner_nxt;
  logic [2:0]          ptr_q, ptr_nxt;
  logic                wr_q, wr_nxt;
  logic [BEAT_W-1:0]   beats_q, beats_nxt;
  logic [BEAT_W-1:0]   beat_cnt, cnt_nxt;

  logic [2:0]          pick_idx;
  logic                pick_any;
  logic [1:0]          pick_len;
  logic                pick_wr_n;

  logic [ADDR_W-1:0]   sel_adr;
  logic [1:0]          sel_len;
  logic                sel_wr_n;
  logic [DATA_W-1:0]   sel_data;
  logic [3:0]          sel_mask;
  logic [NREQ-1:0]     owner_oh;
  logic [2:0]          ptr_after;
  logic                req_strobe;

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req   (m_req),
    .ptr   (ptr_q),
    .grant (pick_idx),
    .any   (pick_any)
  );

  // Field muxes: one selected by the arbitration winner, one by the owner.
  always_comb begin
    pick_len  = '0;
    pick_wr_n = 1'b1;
    sel_adr   = '0;
    sel_len   = '0;
    sel_wr_n  = 1'b1;
    sel_data  = '0;
    sel_mask  = '0;
    owner_oh  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick_idx == 3'(i)) begin
        pick_len  = m_len[i*2 +: 2];
        pick_wr_n = m_wr_n[i];
      end
      if (owner_q == 3'(i)) begin
        sel_adr     = m_adr[i*ADDR_W +: ADDR_W];
        sel_len     = m_len[i*2 +: 2];
        sel_wr_n    = m_wr_n[i];
        sel_data    = m_wr_data[i*DATA_W +: DATA_W];
        sel_mask    = m_wr_en_n[i*4 +: 4];
        owner_oh[i] = 1'b1;
      end
    end
  end

  assign ptr_after  = (owner_q == 3'(NREQ-1)) ? 3'd0 : 3'(owner_q + 3'd1);
  assign req_strobe = wr_q ? sdr_wr_next : sdr_rd_valid;

  // NOTE: every combinational output gets a default before the case so no
  // path through the block leaves a variable unassigned (which would infer a latch).
  always_comb begin
    state_nxt    = state;
    owner_nxt    = owner_q;
    ptr_nxt      = ptr_q;
    wr_nxt       = wr_q;
    beats_nxt    = beats_q;
    cnt_nxt      = beat_cnt;
    m_ack        = '0;
    m_wr_next    = '0;
    m_rd_valid   = '0;
    sdr_req      = 1'b0;
    sdr_req_adr  = '0;
    sdr_req_len  = '0;
    sdr_req_wr_n = 1'b0;
    sdr_wr_data  = '0;
    sdr_wr_en_n  = '0;

    unique case (state)
      ST_IDLE: begin
        if (sdr_init_done && pick_any) begin
          owner_nxt = pick_idx;
          wr_nxt    = ~pick_wr_n;
          beats_nxt = len_to_beats(pick_len);
          state_nxt = ST_REQ;
        end
      end

      ST_REQ: begin
        sdr_req      = 1'b1;
        sdr_req_adr  = sel_adr;
        sdr_req_len  = sel_len;
        sdr_req_wr_n = sel_wr_n;
        sdr_wr_data  = sel_data;
        sdr_wr_en_n  = sel_mask;
        if (sdr_req_ack) begin
          m_ack = owner_oh;
          // The controller may overlap the first beat with the accept.
          if (req_strobe) begin
            if (wr_q) m_wr_next  = owner_oh;
            else      m_rd_valid = owner_oh;
          end
          cnt_nxt = beats_q - BEAT_W'(req_strobe);
          if (req_strobe && beats_q == BEAT_W'(1)) begin
            state_nxt = ST_IDLE;
            ptr_nxt   = ptr_after;
          end else begin
            state_nxt = wr_q ? ST_WDATA : ST_RDATA;
          end
        end
      end

      ST_WDATA: begin
        sdr_wr_data = sel_data;
        sdr_wr_en_n = sel_mask;
        if (sdr_wr_next) m_wr_next = owner_oh;
        if (sdr_wr_next && beat_cnt != '0) begin
          cnt_nxt = beat_cnt - BEAT_W'(1);
          if (beat_cnt == BEAT_W'(1)) begin
            state_nxt = ST_IDLE;
            ptr_nxt   = ptr_after;
          end
        end
      end

      ST_RDATA: begin
        sdr_wr_en_n = 4'hF;
        if (sdr_rd_valid) m_rd_valid = owner_oh;
        if (sdr_rd_valid && beat_cnt != '0) begin
          cnt_nxt = beat_cnt - BEAT_W'(1);
          if (beat_cnt == BEAT_W'(1)) begin
            state_nxt = ST_IDLE;
            ptr_nxt   = ptr_after;
          end
        end
      end

      default: state_nxt = ST_IDLE;
    endcase

    // Nothing leaves the block while reset is asserted.
    if (s_reset) begin
      m_ack        = '0;
      m_wr_next    = '0;
      m_rd_valid   = '0;
      sdr_req      = 1'b0;
      sdr_req_adr  = '0;
      sdr_req_len  = '0;
      sdr_req_wr_n = 1'b0;
      sdr_wr_data  = '0;
      sdr_wr_en_n  = '0;
    end
  end

  // NOTE: state uses non-blocking assignments so every register samples the
  // values from before this edge, regardless of statement order.
  always_ff @(posedge mclk) begin
    if (s_reset) begin
      state    <= ST_IDLE;
      owner_q  <= '0;
      ptr_q    <= '0;
      wr_q     <= 1'b0;
      beats_q  <= '0;
      beat_cnt <= '0;
    end else begin
      state    <= state_nxt;
      owner_q  <= owner_nxt;
      ptr_q    <= ptr_nxt;
      wr_q     <= wr_nxt;
      beats_q  <= beats_nxt;
      beat_cnt <= cnt_nxt;
    end
  end

  assign busy  = (state != ST_IDLE);
  assign owner = owner_q;

endmodule

// File: tb/tb_sdc_host_arb.sv
// Self-checking bench for sdc_host_arb: expected grants are queued when
// requests are raised and compared when the arbiter presents sdr_req.
module tb_sdc_host_arb;

  localparam int NREQ = 4;
  localparam int AW   = 22;
  localparam int DW   = 32;

  typedef struct {
    int          idx;
    logic [AW-1:0] adr;
    logic [1:0]  len;
    logic        wr_n;
  } grant_t;

  logic                 mclk;
  logic                 s_reset;
  logic [NREQ-1:0]      m_req;
  logic [NREQ*AW-1:0]   m_adr;
  logic [NREQ*2-1:0]    m_len;
  logic [NREQ-1:0]      m_wr_n;
  logic [NREQ*DW-1:0]   m_wr_data;
  logic [NREQ*4-1:0]    m_wr_en_n;
  logic [NREQ-1:0]      m_ack, m_wr_next, m_rd_valid;
  logic                 sdr_init_done;
  logic                 sdr_req;
  logic [AW-1:0]        sdr_req_adr;
  logic [1:0]           sdr_req_len;
  logic                 sdr_req_wr_n;
  logic [DW-1:0]        sdr_wr_data;
  logic [3:0]           sdr_wr_en_n;
  logic                 sdr_req_ack, sdr_wr_next, sdr_rd_valid;
  logic                 busy;
  logic [2:0]           owner;

  logic [AW-1:0] adr_a  [NREQ];
  logic [1:0]    len_a  [NREQ];
  logic          wr_n_a [NREQ];
  logic [DW-1:0] data_a [NREQ];
  logic [3:0]    mask_a [NREQ];

  grant_t exp_q[$];
  int n_vec = 0;
  int n_err = 0;

  sdc_host_arb #(.NREQ(NREQ), .ADDR_W(AW), .DATA_W(DW)) dut (
    .mclk          (mclk),
    .s_reset       (s_reset),
    .m_req         (m_req),
    .m_adr         (m_adr),
    .m_len         (m_len),
    .m_wr_n        (m_wr_n),
    .m_wr_data     (m_wr_data),
    .m_wr_en_n     (m_wr_en_n),
    .m_ack         (m_ack),
    .m_wr_next     (m_wr_next),
    .m_rd_valid    (m_rd_valid),
    .sdr_init_done (sdr_init_done),
    .sdr_req       (sdr_req),
    .sdr_req_adr   (sdr_req_adr),
    .sdr_req_len   (sdr_req_len),
    .sdr_req_wr_n  (sdr_req_wr_n),
    .sdr_wr_data   (sdr_wr_data),
    .sdr_wr_en_n   (sdr_wr_en_n),
    .sdr_req_ack   (sdr_req_ack),
    .sdr_wr_next   (sdr_wr_next),
    .sdr_rd_valid  (sdr_rd_valid),
    .busy          (busy),
    .owner         (owner)
  );

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      m_adr[i*AW +: AW]     = adr_a[i];
      m_len[i*2 +: 2]       = len_a[i];
      m_wr_n[i]             = wr_n_a[i];
      m_wr_data[i*DW +: DW] = data_a[i];
      m_wr_en_n[i*4 +: 4]   = mask_a[i];
    end
  end

  initial mclk = 1'b0;
  always #5 mclk = ~mclk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge mclk);
    #1;
  endtask

  task automatic apply_reset();
    s_reset = 1'b1;
    tick();
    tick();
    s_reset = 1'b0;
  endtask

  task automatic push_grant(input int idx);
    grant_t g;
    g.idx  = idx;
    g.adr  = adr_a[idx];
    g.len  = len_a[idx];
    g.wr_n = wr_n_a[idx];
    exp_q.push_back(g);
  endtask

  // Acts as the controller for one queued grant. drop: 0 keep m_req,
  // 1 clear the owner's bit after ack, 2 clear all. abort_after > 0 asserts
  // s_reset after that many data beats.
  task automatic run_txn(input int beats, input bit overlap, input int drop, input int abort_after);
    grant_t e;
    int n;
    int pulses;
    int got;
    logic [NREQ-1:0] oh;
    logic [NREQ-1:0] strobe_out;
    n = 0;
    while (!sdr_req && n < 40) begin
      tick();
      n++;
    end
    if (!sdr_req) begin
      check("req_timeout", 64'(sdr_req), 64'd1);
      return;
    end
    if (exp_q.size() == 0) begin
      check("sb_underflow", 64'(exp_q.size()), 64'd1);
      return;
    end
    e  = exp_q.pop_front();
    oh = NREQ'(1) << e.idx;
    check("owner", 64'(owner), 64'(e.idx));
    check("req_adr", 64'(sdr_req_adr), 64'(e.adr));
    check("req_len", 64'(sdr_req_len), 64'(e.len));
    check("req_wr_n", 64'(sdr_req_wr_n), 64'(e.wr_n));
    check("busy_req", 64'(busy), 64'd1);

    pulses = 0;
    got    = 0;
    sdr_req_ack = 1'b1;
    if (overlap) begin
      if (e.wr_n) sdr_rd_valid = 1'b1;
      else        sdr_wr_next  = 1'b1;
    end
    #1;
    check("ack_onehot", 64'(m_ack), 64'(oh));
    if (overlap) begin
      strobe_out = e.wr_n ? m_rd_valid : m_wr_next;
      check("ack_beat", 64'(strobe_out), 64'(oh));
      if (strobe_out[e.idx]) pulses++;
      got = 1;
    end
    tick();
    sdr_req_ack  = 1'b0;
    sdr_wr_next  = 1'b0;
    sdr_rd_valid = 1'b0;
    if (drop == 1) m_req[e.idx] = 1'b0;
    else if (drop == 2) m_req = '0;
    #1;
    check("ack_pulse", 64'(m_ack), 64'd0);

    while (got < beats) begin
      strobe_out = e.wr_n ? m_rd_valid : m_wr_next;
      check("no_strobe", 64'(strobe_out), 64'd0);
      if (!e.wr_n) begin
        data_a[e.idx] = $urandom;
        mask_a[e.idx] = 4'($urandom);
        sdr_wr_next   = 1'b1;
      end else begin
        sdr_rd_valid  = 1'b1;
      end
      #1;
      if (!e.wr_n) begin
        check("wr_next", 64'(m_wr_next), 64'(oh));
        check("wr_data", 64'(sdr_wr_data), 64'(data_a[e.idx]));
        check("wr_mask", 64'(sdr_wr_en_n), 64'(mask_a[e.idx]));
        if (m_wr_next[e.idx]) pulses++;
      end else begin
        check("rd_valid", 64'(m_rd_valid), 64'(oh));
        check("rd_mask", 64'(sdr_wr_en_n), 64'hF);
        if (m_rd_valid[e.idx]) pulses++;
      end
      got++;
      tick();
      sdr_wr_next  = 1'b0;
      sdr_rd_valid = 1'b0;
      if (got == abort_after) begin
        s_reset     = 1'b1;
        sdr_wr_next = 1'b1;
        #1;
        check("rst_no_strobe", 64'(m_wr_next), 64'd0);
        tick();
        s_reset = 1'b0;
        #1;
        check("rst_req", 64'(sdr_req), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_owner", 64'(owner), 64'd0);
        check("rst_wr_next", 64'(m_wr_next), 64'd0);
        check("rst_wr_data", 64'(sdr_wr_data), 64'd0);
        check("rst_wr_en_n", 64'(sdr_wr_en_n), 64'd0);
        sdr_wr_next = 1'b0;
        return;
      end
      #1;
    end
    check("beat_count", 64'(pulses), 64'(beats));
    check("busy_done", 64'(busy), 64'd0);
  endtask

  initial begin
    int hi_seen;
    s_reset       = 1'b1;
    m_req         = '0;
    sdr_init_done = 1'b0;
    sdr_req_ack   = 1'b0;
    sdr_wr_next   = 1'b0;
    sdr_rd_valid  = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      adr_a[i]  = AW'(22'h01_0000 * (i + 1) + 22'h123);
      len_a[i]  = 2'd0;
      wr_n_a[i] = 1'b1;
      data_a[i] = 32'hA5A5_0000 + 32'(i);
      mask_a[i] = 4'(i);
    end
    apply_reset();

    // Reset state
    check("rst_sdr_req", 64'(sdr_req), 64'd0);
    check("rst_busy0", 64'(busy), 64'd0);
    check("rst_owner0", 64'(owner), 64'd0);
    check("rst_m_ack", 64'(m_ack), 64'd0);
    check("rst_wr_data0", 64'(sdr_wr_data), 64'd0);

    // 1: no arbitration until init is done; then one-cycle latency
    m_req   = 4'b0001;
    hi_seen = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (sdr_req) hi_seen++;
    end
    check("init_gate", 64'(hi_seen), 64'd0);
    push_grant(0);
    sdr_init_done = 1'b1;
    #1;
    check("req_same_cycle", 64'(sdr_req), 64'd0);
    tick();
    check("req_rise", 64'(sdr_req), 64'd1);
    run_txn(1, 1'b0, 1, 0);

    // 2: master 2 writes a 4-beat burst
    len_a[2]  = 2'd2;
    wr_n_a[2] = 1'b0;
    push_grant(2);
    m_req = 4'b0100;
    run_txn(4, 1'b0, 1, 0);

    // 3: all masters requesting, single-beat reads, fresh pointer
    apply_reset();
    len_a[2]  = 2'd0;
    wr_n_a[2] = 1'b1;
    for (int k = 0; k < 8; k++) push_grant(k % NREQ);
    m_req = 4'b1111;
    for (int k = 0; k < 8; k++) run_txn(1, 1'b0, (k == 7) ? 2 : 0, 0);

    // 4: 8-beat read with the first beat overlapping the ack
    len_a[1] = 2'd3;
    push_grant(1);
    m_req = 4'b0010;
    run_txn(8, 1'b1, 1, 0);

    // 5: reset in the middle of an 8-beat write; pointer returns to master 0
    len_a[3]  = 2'd3;
    wr_n_a[3] = 1'b0;
    push_grant(3);
    m_req = 4'b1000;
    run_txn(8, 1'b0, 1, 3);
    len_a[1]  = 2'd0;
    len_a[3]  = 2'd0;
    wr_n_a[3] = 1'b1;
    push_grant(1);
    push_grant(3);
    m_req = 4'b1010;
    run_txn(1, 1'b0, 1, 0);
    run_txn(1, 1'b0, 1, 0);

    // 6: stray strobes while idle are ignored
    tick();
    sdr_rd_valid = 1'b1;
    sdr_wr_next  = 1'b1;
    sdr_req_ack  = 1'b1;
    #1;
    check("idle_rd_valid", 64'(m_rd_valid), 64'd0);
    check("idle_wr_next", 64'(m_wr_next), 64'd0);
    check("idle_ack", 64'(m_ack), 64'd0);
    check("idle_wr_data", 64'(sdr_wr_data), 64'd0);
    tick();
    sdr_rd_valid = 1'b0;
    sdr_wr_next  = 1'b0;
    sdr_req_ack  = 1'b0;
    #1;
    check("idle_busy", 64'(busy), 64'd0);
    check("idle_req", 64'(sdr_req), 64'd0);
    push_grant(2);
    m_req = 4'b0100;
    run_txn(1, 1'b0, 1, 0);

    check("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
